// File: rtl/wash_pkg.sv
// Shared types and phase sequencing for the wash cycle sequencer.
package wash_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READY = 3'd1;
    localparam logic [2:0] S_SOAK  = 3'd2;
    localparam logic [2:0] S_WASH  = 3'd3;
    localparam logic [2:0] S_RINSE = 3'd4;
    localparam logic [2:0] S_SPIN  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE  = S_IDLE,
        ST_READY = S_READY,
        ST_SOAK  = S_SOAK,
        ST_WASH  = S_WASH,
        ST_RINSE = S_RINSE,
        ST_SPIN  = S_SPIN,
        ST_DONE  = S_DONE
    } state_t;

    typedef enum logic [1:0] {
        MODE_FULL  = 2'd0,
        MODE_STD   = 2'd1,
        MODE_RINSE = 2'd2,
        MODE_SPIN  = 2'd3
    } mode_t;

    // Successor of a phase; from any non-phase state, the program's first phase.
    function automatic state_t next_phase(input state_t state, input mode_t mode,
                                          input logic second_rinse_pending);
        state_t nxt;
        case (state)
            ST_SOAK:  nxt = ST_WASH;
            ST_WASH:  nxt = ST_RINSE;
            ST_RINSE: nxt = second_rinse_pending ? ST_RINSE : ST_SPIN;
            ST_SPIN:  nxt = ST_DONE;
            default: begin
                case (mode)
                    MODE_FULL:  nxt = ST_SOAK;
                    MODE_STD:   nxt = ST_WASH;
                    MODE_RINSE: nxt = ST_RINSE;
                    default:    nxt = ST_SPIN;
                endcase
            end
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/wash_phase_timer.sv
// Prescaled phase down-counter: load on phase entry, hold while paused, flag expiry.
module wash_phase_timer #(
    parameter int unsigned TIMER_W  = 16,
    parameter int unsigned TICK_DIV = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               load,
    input  logic               clear,
    input  logic               hold,
    input  logic [TIMER_W-1:0] load_value,
    output logic               tick_c,
    output logic               expire_c,
    output logic [TIMER_W-1:0] count
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PRE_W-1:0] pre;

    assign tick_c   = run && !hold && (pre == PRE_W'(TICK_DIV - 1));
    assign expire_c = tick_c && (count == '0);

    // Clear/load win over ticking so a phase change always starts a fresh period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre   <= '0;
            count <= '0;
        end else if (clear) begin
            pre   <= '0;
            count <= '0;
        end else if (load) begin
            pre   <= '0;
            count <= load_value;
        end else if (tick_c) begin
            pre <= '0;
            if (count != '0) begin
                count <= count - TIMER_W'(1);
            end
        end else if (run && !hold) begin
            pre <= pre + PRE_W'(1);
        end
    end

endmodule

// File: rtl/wash_cycle_sequencer.sv
// Coin-operated wash program sequencer (SOAK/WASH/RINSE/SPIN) with pause and abort.
// Optional double rinse enabled by defining EXTRA_RINSE_EN.
module wash_cycle_sequencer
    import wash_pkg::*;
#(
    parameter int unsigned TIMER_W     = 16,
    parameter int unsigned CREDIT_W    = 4,
    parameter int unsigned PRICE       = 2,
    parameter int unsigned TICK_DIV    = 1,
    parameter int unsigned SOAK_TICKS  = 4,
    parameter int unsigned WASH_TICKS  = 5,
    parameter int unsigned RINSE_TICKS = 3,
    parameter int unsigned SPIN_TICKS  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_inserted,
    input  logic                start_button,
    input  logic [1:0]          mode_sel,
    input  logic                pause,
    input  logic                abort,
    input  logic                extra_rinse,
    output logic                ready_signal,
    output logic                soak_signal,
    output logic                wash_signal,
    output logic                rinse_signal,
    output logic                spin_signal,
    output logic                paused_signal,
    output logic                done_pulse,
    output logic [CREDIT_W-1:0] credit,
    output logic [TIMER_W-1:0]  time_left
);

    localparam logic [CREDIT_W-1:0] CREDIT_MAX = '1;
    localparam logic [CREDIT_W-1:0] PRICE_C    = CREDIT_W'(PRICE);

    state_t              state, state_next;
    mode_t               mode_q, mode_next;
    logic                rinse_again_q, rinse_again_next;
    logic [CREDIT_W-1:0] credit_next;
    logic                eligible_c, in_phase_c;
    logic                tmr_load, tmr_clear, tmr_hold;
    logic [TIMER_W-1:0]  tmr_value;
    logic                tick_c, expire_c;

`ifndef EXTRA_RINSE_EN
    logic unused_extra_rinse;
    assign unused_extra_rinse = extra_rinse;
`endif

    function automatic logic [TIMER_W-1:0] ticks_for(input state_t s);
        case (s)
            ST_SOAK:  return TIMER_W'(SOAK_TICKS - 1);
            ST_WASH:  return TIMER_W'(WASH_TICKS - 1);
            ST_RINSE: return TIMER_W'(RINSE_TICKS - 1);
            ST_SPIN:  return TIMER_W'(SPIN_TICKS - 1);
            default:  return '0;
        endcase
    endfunction

    assign eligible_c = (credit >= PRICE_C);
    assign in_phase_c = (state == ST_SOAK) || (state == ST_WASH) ||
                        (state == ST_RINSE) || (state == ST_SPIN);

    wash_phase_timer #(
        .TIMER_W (TIMER_W),
        .TICK_DIV(TICK_DIV)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .run       (in_phase_c),
        .load      (tmr_load),
        .clear     (tmr_clear),
        .hold      (tmr_hold),
        .load_value(tmr_value),
        .tick_c    (tick_c),
        .expire_c  (expire_c),
        .count     (time_left)
    );

    // State, latched program and credit registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            mode_q        <= MODE_FULL;
            rinse_again_q <= 1'b0;
            credit        <= '0;
        end else begin
            state         <= state_next;
            mode_q        <= mode_next;
            rinse_again_q <= rinse_again_next;
            credit        <= credit_next;
        end
    end

    // Next-state, credit and timer control.
    always_comb begin
        state_next       = state;
        mode_next        = mode_q;
        rinse_again_next = rinse_again_q;
        tmr_load         = 1'b0;
        tmr_clear        = 1'b0;
        tmr_hold         = 1'b0;
        tmr_value        = '0;
        credit_next      = credit;
        if (coin_inserted && (credit != CREDIT_MAX)) begin
            credit_next = credit + CREDIT_W'(1);
        end

        case (state)
            ST_IDLE: begin
                if (eligible_c) begin
                    state_next = ST_READY;
                end
            end
            ST_READY: begin
                if (start_button) begin
                    mode_next = mode_t'(mode_sel);
`ifdef EXTRA_RINSE_EN
                    rinse_again_next = extra_rinse;
`else
                    rinse_again_next = 1'b0;
`endif
                    // READY implies credit >= PRICE, so this cannot overflow.
                    credit_next = credit - PRICE_C + CREDIT_W'(coin_inserted);
                    state_next  = next_phase(ST_READY, mode_t'(mode_sel), 1'b0);
                    tmr_load    = 1'b1;
                    tmr_value   = ticks_for(state_next);
                end
            end
            ST_SOAK, ST_WASH, ST_RINSE, ST_SPIN: begin
                if (abort) begin
                    state_next       = eligible_c ? ST_READY : ST_IDLE;
                    rinse_again_next = 1'b0;
                    tmr_clear        = 1'b1;
                end else if (pause) begin
                    tmr_hold = 1'b1;
                end else if (expire_c) begin
                    state_next = next_phase(state, mode_q, rinse_again_q);
                    if (state == ST_RINSE) begin
                        rinse_again_next = 1'b0;
                    end
                    if (state_next == ST_DONE) begin
                        tmr_clear = 1'b1;
                    end else begin
                        tmr_load  = 1'b1;
                        tmr_value = ticks_for(state_next);
                    end
                end
            end
            ST_DONE: begin
                state_next = eligible_c ? ST_READY : ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Indicators registered from the next state so they align with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_signal  <= 1'b0;
            soak_signal   <= 1'b0;
            wash_signal   <= 1'b0;
            rinse_signal  <= 1'b0;
            spin_signal   <= 1'b0;
            paused_signal <= 1'b0;
            done_pulse    <= 1'b0;
        end else begin
            ready_signal  <= (state_next == ST_READY);
            soak_signal   <= (state_next == ST_SOAK);
            wash_signal   <= (state_next == ST_WASH);
            rinse_signal  <= (state_next == ST_RINSE);
            spin_signal   <= (state_next == ST_SPIN);
            paused_signal <= tmr_hold;
            done_pulse    <= (state_next == ST_DONE);
        end
    end

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
// Self-checking bench: directed scenarios plus random stimulus against a queue-based program model.
module tb_wash_cycle_sequencer;

    localparam int unsigned TIMER_W     = 16;
    localparam int unsigned CREDIT_W    = 4;
    localparam int unsigned PRICE       = 2;
    localparam int unsigned TICK_DIV    = 1;
    localparam int unsigned SOAK_TICKS  = 4;
    localparam int unsigned WASH_TICKS  = 5;
    localparam int unsigned RINSE_TICKS = 3;
    localparam int unsigned SPIN_TICKS  = 2;
    localparam int          CMAX        = (1 << CREDIT_W) - 1;

    logic                clk = 1'b0;
    logic                reset;
    logic                coin_inserted, start_button, pause, abort, extra_rinse;
    logic [1:0]          mode_sel;
    logic                ready_signal, soak_signal, wash_signal, rinse_signal, spin_signal;
    logic                paused_signal, done_pulse;
    logic [CREDIT_W-1:0] credit;
    logic [TIMER_W-1:0]  time_left;

    always #5 clk = ~clk;

    wash_cycle_sequencer #(
        .TIMER_W(TIMER_W), .CREDIT_W(CREDIT_W), .PRICE(PRICE), .TICK_DIV(TICK_DIV),
        .SOAK_TICKS(SOAK_TICKS), .WASH_TICKS(WASH_TICKS),
        .RINSE_TICKS(RINSE_TICKS), .SPIN_TICKS(SPIN_TICKS)
    ) dut (
        .clk(clk), .reset(reset), .coin_inserted(coin_inserted),
        .start_button(start_button), .mode_sel(mode_sel), .pause(pause),
        .abort(abort), .extra_rinse(extra_rinse), .ready_signal(ready_signal),
        .soak_signal(soak_signal), .wash_signal(wash_signal),
        .rinse_signal(rinse_signal), .spin_signal(spin_signal),
        .paused_signal(paused_signal), .done_pulse(done_pulse),
        .credit(credit), .time_left(time_left)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: coarse machine state plus a queue of the program's remaining phases.
    typedef enum int {M_IDLE, M_READY, M_PHASE, M_DONE} mstate_e;
    mstate_e m_st;
    int      m_credit, m_phase, m_left, m_pre;
    bit      m_paused;
    int      m_prog[$];
    int      phase_len[4] = '{SOAK_TICKS, WASH_TICKS, RINSE_TICKS, SPIN_TICKS};

    function automatic void m_reset();
        m_st = M_IDLE; m_credit = 0; m_phase = 0; m_left = 0; m_pre = 0;
        m_paused = 1'b0; m_prog.delete();
    endfunction

    function automatic void m_enter();
        m_phase = m_prog.pop_front();
        m_left  = phase_len[m_phase] - 1;
        m_pre   = 0;
        m_st    = M_PHASE;
    endfunction

    function automatic void model_step(input bit coin, input bit start, input int mode,
                                       input bit pz, input bit ab, input bit xr);
        int nc;
        bit elig;
        elig = (m_credit >= PRICE);
        nc = (m_st == M_READY && start) ? m_credit - PRICE + int'(coin) : m_credit + int'(coin);
        if (nc > CMAX) nc = CMAX;
        m_paused = 1'b0;
        case (m_st)
            M_IDLE:  if (elig) m_st = M_READY;
            M_READY: begin
                if (start) begin
                    m_prog.delete();
                    for (int p = mode; p < 4; p++) begin
                        m_prog.push_back(p);
`ifdef EXTRA_RINSE_EN
                        if (p == 2 && xr) m_prog.push_back(2);
`endif
                    end
                    m_enter();
                end
            end
            M_PHASE: begin
                if (ab) begin
                    m_st = elig ? M_READY : M_IDLE;
                    m_left = 0;
                end else if (pz) begin
                    m_paused = 1'b1;
                end else begin
                    m_pre++;
                    if (m_pre >= TICK_DIV) begin
                        m_pre = 0;
                        if (m_left == 0) begin
                            if (m_prog.size() == 0) begin
                                m_st = M_DONE;
                                m_left = 0;
                            end else begin
                                m_enter();
                            end
                        end else begin
                            m_left--;
                        end
                    end
                end
            end
            default: m_st = elig ? M_READY : M_IDLE;
        endcase
        m_credit = nc;
        if (xr) begin end
    endfunction

    task automatic check_all();
        check("ready", 32'(ready_signal), 32'(m_st == M_READY));
        check("soak", 32'(soak_signal), 32'(m_st == M_PHASE && m_phase == 0));
        check("wash", 32'(wash_signal), 32'(m_st == M_PHASE && m_phase == 1));
        check("rinse", 32'(rinse_signal), 32'(m_st == M_PHASE && m_phase == 2));
        check("spin", 32'(spin_signal), 32'(m_st == M_PHASE && m_phase == 3));
        check("paused", 32'(paused_signal), 32'(m_paused));
        check("done", 32'(done_pulse), 32'(m_st == M_DONE));
        check("credit", 32'(credit), 32'(m_credit));
        check("time_left", 32'(time_left), (m_st == M_PHASE) ? 32'(m_left) : 32'd0);
    endtask

    task automatic cycle(input bit coin, input bit start, input int mode,
                         input bit pz, input bit ab, input bit xr);
        coin_inserted = coin; start_button = start; mode_sel = 2'(mode);
        pause = pz; abort = ab; extra_rinse = xr;
        @(posedge clk);
        model_step(coin, start, mode, pz, ab, xr);
        #1;
        check_all();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, int'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        coin_inserted = 1'b0; start_button = 1'b0; mode_sel = 2'd0;
        pause = 1'b0; abort = 1'b0; extra_rinse = 1'b0;
        reset = 1'b1;
        #12;
        m_reset();
        check_all();
        @(negedge clk);
        reset = 1'b0;

        // Credit accumulation and READY one cycle after reaching the price.
        cycle(1, 0, 0, 0, 0, 0);
        check("credit_one", 32'(credit), 32'd1);
        cycle(1, 0, 0, 0, 0, 0);
        check("not_ready_yet", 32'(ready_signal), 32'd0);
        cycle(0, 0, 0, 0, 0, 0);
        check("ready_after_price", 32'(ready_signal), 32'd1);

        // Full program, mode_sel wiggled while running.
        cycle(0, 1, 0, 0, 0, 0);
        idle_cycles(18);

        // Spin-only program.
        cycle(1, 0, 3, 0, 0, 0); cycle(1, 0, 3, 0, 0, 0); cycle(0, 0, 3, 0, 0, 0);
        cycle(0, 1, 3, 0, 0, 0);
        idle_cycles(5);

        // Pause in WASH at time_left 2 for 10 cycles.
        cycle(1, 0, 1, 0, 0, 0); cycle(1, 0, 1, 0, 0, 0); cycle(0, 0, 1, 0, 0, 0);
        cycle(0, 1, 1, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 0); cycle(0, 0, 1, 0, 0, 0);
        check("pause_point", 32'(time_left), 32'd2);
        for (int i = 0; i < 10; i++) cycle(0, 0, 1, 1, 0, 0);
        check("paused_frozen", 32'(time_left), 32'd2);
        idle_cycles(12);

        // Abort in RINSE.
        cycle(1, 0, 2, 0, 0, 0); cycle(1, 0, 2, 0, 0, 0); cycle(0, 0, 2, 0, 0, 0);
        cycle(0, 1, 2, 0, 0, 0);
        cycle(0, 0, 2, 0, 0, 0);
        cycle(0, 0, 2, 0, 1, 0);
        idle_cycles(3);

        // Saturation, then start with a coin on the same cycle; also the double rinse request.
        for (int i = 0; i < 20; i++) cycle(1, 0, 0, 0, 0, 0);
        check("credit_saturated", 32'(credit), 32'(CMAX));
        cycle(1, 1, 2, 0, 0, 1);
        check("credit_after_start", 32'(credit), 32'(CMAX - PRICE + 1));
        idle_cycles(12);

        // Asynchronous reset in the middle of SOAK.
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        m_reset();
        check_all();
        @(negedge clk);
        reset = 1'b0;

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom % 3) == 0, ($urandom % 3) == 0, int'($urandom_range(0, 3)),
                  ($urandom % 8) == 0, ($urandom % 40) == 0, ($urandom % 2) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
